// File: rtl/noc_inject_arbiter.sv
// ---------------------------------------------------------------------------
// noc_inject_arbiter
//
// Shares one NoC router injection (sender) port among NUM_REQ local
// requesters. The arbitration is wormhole-aware. A requester wins with a
// header flit and then keeps the port until its tail flit has been loaded.
// Packets are served round-robin. A single registered output stage drives
// the router.
//
// Ports:
//   noc_clk          clock, rising edge
//   rst_n            asynchronous active-low reset
//   req_valid        per-requester flit valid
//   req_ready        per-requester flit accepted this cycle (combinational)
//   req_flit         requester i flit at [i*DATA_W +: DATA_W]
//   req_is_header    per-requester header marker
//   req_is_tail      per-requester tail marker (header & tail = 1-flit packet)
//   sender_valid     registered flit valid towards the router
//   sender_ready     router accepts the flit
//   sender_vc_ready  router VC free for a new packet (arbitration only)
//   sender_flit      flit towards the router
//   sender_is_header header marker towards the router
//   sender_is_tail   tail marker towards the router
//   owner_idx        current/last granted requester
//   proto_err        sticky: non-header flit offered while no owner is held
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module noc_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 2
) (
  input  logic                      noc_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  output logic                      sender_valid,
  input  logic                      sender_ready,
  input  logic                      sender_vc_ready,
  output logic [DATA_W-1:0]         sender_flit,
  output logic                      sender_is_header,
  output logic                      sender_is_tail,
  output logic [IDX_W-1:0]          owner_idx,
  output logic                      proto_err
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic                r_proto_err;
  logic                r_sender_valid;
  logic [DATA_W-1:0]   r_sender_flit;
  logic                r_sender_is_header;
  logic                r_sender_is_tail;

  logic [NUM_REQ-1:0]  w_cand;
  logic                w_grant_any;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_grant;
  logic                w_out_fire;
  logic                w_out_free;
  logic                w_load;
  logic                w_tail_load;
  logic                w_err_flit;
  logic [IDX_W-1:0]    w_owner_inc;
  logic [DATA_W-1:0]   w_flits [NUM_REQ];

  // Unpack the flat flit bus so the owner's flit can be picked by index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_flits[g] = req_flit[g*DATA_W +: DATA_W];
  end

  assign w_cand      = req_valid & req_is_header;
  assign w_out_fire  = r_sender_valid & sender_ready;
  assign w_out_free  = ~r_sender_valid | w_out_fire;
  assign w_grant     = (r_state == ST_IDLE) & w_grant_any & sender_vc_ready;
  assign w_load      = (r_state == ST_LOCKED) & req_valid[r_owner] & w_out_free;
  assign w_tail_load = w_load & req_is_tail[r_owner];
  assign w_err_flit  = |(req_valid & ~req_is_header);
  assign w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  // Round-robin search: the first header candidate at or after rr_ptr,
  // wrapping around. The sum is one bit wider so the wrap works for any
  // NUM_REQ, including values that are not a power of two.
  always_comb begin : p_arb
    logic [IDX_W:0] sum;
    sum         = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_grant_any && w_cand[sum[IDX_W-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = sum[IDX_W-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. The lock is released as soon as the tail is loaded
  // into the output register, so the next IDLE cycle can arbitrate while
  // the tail is still waiting for the router.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant)     w_next_state = ST_LOCKED;
      ST_LOCKED: if (w_tail_load) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output logic. Only the owner is ever acknowledged, and only while the
  // output register can take a flit.
  always_comb begin
    req_ready = '0;
    if (r_state == ST_LOCKED) begin
      req_ready[r_owner] = w_out_free;
    end
  end

  // Owner, round-robin pointer and sticky protocol error.
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_idx;
      end
      if (w_tail_load) begin
        r_rr_ptr <= w_owner_inc;
      end
      if ((r_state == ST_IDLE) && w_err_flit) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Output register. A load takes priority over a fire in the same cycle,
  // so valid stays high when a new flit replaces the departing one.
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sender_valid     <= 1'b0;
      r_sender_flit      <= '0;
      r_sender_is_header <= 1'b0;
      r_sender_is_tail   <= 1'b0;
    end else if (w_load) begin
      r_sender_valid     <= 1'b1;
      r_sender_flit      <= w_flits[r_owner];
      r_sender_is_header <= req_is_header[r_owner];
      r_sender_is_tail   <= req_is_tail[r_owner];
    end else if (w_out_fire) begin
      r_sender_valid     <= 1'b0;
    end
  end

  assign sender_valid     = r_sender_valid;
  assign sender_flit      = r_sender_flit;
  assign sender_is_header = r_sender_is_header;
  assign sender_is_tail   = r_sender_is_tail;
  assign owner_idx        = r_owner;
  assign proto_err        = r_proto_err;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_inject_arbiter
//
// Per-requester source queues feed the DUT. Every expected router-side flit
// is pushed into a scoreboard queue in the order worked out by hand, and a
// monitor pops and compares each time the router side accepts a flit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_noc_inject_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 2;
  localparam int SRC_D   = 64;

  logic                      noc_clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_is_header;
  logic [NUM_REQ-1:0]        req_is_tail;
  logic                      sender_valid;
  logic                      sender_ready;
  logic                      sender_vc_ready;
  logic [DATA_W-1:0]         sender_flit;
  logic                      sender_is_header;
  logic                      sender_is_tail;
  logic [IDX_W-1:0]          owner_idx;
  logic                      proto_err;

  // Source entries are {header, tail, flit}.
  logic [DATA_W+1:0] srcMem [NUM_REQ][SRC_D];
  int                srcWr  [NUM_REQ];
  int                srcRd  [NUM_REQ];
  bit                srcHold[NUM_REQ];
  logic [NUM_REQ-1:0] fireSeen;
  logic [DATA_W+1:0] expQ[$];

  int nTests = 0;
  int nFail  = 0;

  noc_inject_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDX_W(IDX_W)
  ) dut (
    .noc_clk         (noc_clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_flit        (req_flit),
    .req_is_header   (req_is_header),
    .req_is_tail     (req_is_tail),
    .sender_valid    (sender_valid),
    .sender_ready    (sender_ready),
    .sender_vc_ready (sender_vc_ready),
    .sender_flit     (sender_flit),
    .sender_is_header(sender_is_header),
    .sender_is_tail  (sender_is_tail),
    .owner_idx       (owner_idx),
    .proto_err       (proto_err)
  );

  always #5 noc_clk = ~noc_clk;

  function automatic logic [DATA_W-1:0] mkFlit(int req, int pkt, int k);
    return {8'(req), 8'(pkt), 16'(k)};
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue an n-flit packet on requester req (header first, tail last).
  task automatic applyStimulus(int req, int pkt, int n);
    for (int k = 0; k < n; k++) begin
      srcMem[req][srcWr[req]] = {1'(k == 0), 1'(k == n - 1), mkFlit(req, pkt, k)};
      srcWr[req]++;
    end
  endtask

  task automatic applyRaw(int req, logic hdr, logic tail, logic [DATA_W-1:0] flit);
    srcMem[req][srcWr[req]] = {hdr, tail, flit};
    srcWr[req]++;
  endtask

  // Hand-ordered expectation of what the router side must see.
  task automatic expectPacket(int req, int pkt, int n);
    for (int k = 0; k < n; k++) begin
      expQ.push_back({1'(k == 0), 1'(k == n - 1), mkFlit(req, pkt, k)});
    end
  endtask

  // Assert reset, check that every output is cleared at once, flush the
  // sources and the scoreboard, then release.
  task automatic doReset();
    @(posedge noc_clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_sender_valid", 64'(sender_valid), 64'd0);
    checkOutput("rst_sender_flit",  64'(sender_flit), 64'd0);
    checkOutput("rst_sender_hdr",   64'(sender_is_header), 64'd0);
    checkOutput("rst_sender_tail",  64'(sender_is_tail), 64'd0);
    checkOutput("rst_owner_idx",    64'(owner_idx), 64'd0);
    checkOutput("rst_proto_err",    64'(proto_err), 64'd0);
    checkOutput("rst_req_ready",    64'(req_ready), 64'd0);
    expQ.delete();
    repeat (2) @(negedge noc_clk);
    #5;
    for (int i = 0; i < NUM_REQ; i++) begin
      srcWr[i] = 0; srcRd[i] = 0; srcHold[i] = 1'b0;
    end
    @(posedge noc_clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic waitDrain(int budget);
    int c = 0;
    while (expQ.size() != 0 && c < budget) begin
      @(posedge noc_clk);
      c++;
    end
    checkOutput("drain", 64'(expQ.size()), 64'd0);
    repeat (2) @(posedge noc_clk);
    #1;
  endtask

  task automatic waitValid(int budget);
    int c = 0;
    while (!sender_valid && c < budget) begin
      @(posedge noc_clk); #1;
      c++;
    end
    checkOutput("wait_valid", 64'(sender_valid), 64'd1);
  endtask

  // Requester driver: pops on the handshake seen just before the previous
  // rising edge, then presents the next queued flit.
  initial begin
    req_valid = '0; req_flit = '0; req_is_header = '0; req_is_tail = '0;
    fireSeen = '0;
    forever begin
      @(negedge noc_clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fireSeen[i]) srcRd[i]++;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (srcRd[i] < srcWr[i] && !srcHold[i]) begin
          req_valid[i] = 1'b1;
          {req_is_header[i], req_is_tail[i], req_flit[i*DATA_W +: DATA_W]} = srcMem[i][srcRd[i]];
        end else begin
          req_valid[i] = 1'b0;
          req_is_header[i] = 1'b0;
          req_is_tail[i] = 1'b0;
          req_flit[i*DATA_W +: DATA_W] = '0;
        end
      end
      #4;
      fireSeen = rst_n ? (req_valid & req_ready) : '0;
    end
  end

  // Monitor: compares each accepted flit against the scoreboard and checks
  // that a stalled flit is held stable.
  logic              prevValid;
  logic              prevReady;
  logic [DATA_W+1:0] prevData;
  logic [DATA_W+1:0] actData;
  logic [DATA_W+1:0] expData;

  initial begin
    prevValid = 1'b0; prevReady = 1'b0; prevData = '0;
    forever begin
      @(negedge noc_clk);
      #4;
      if (!rst_n) begin
        prevValid = 1'b0;
      end else begin
        actData = {sender_is_header, sender_is_tail, sender_flit};
        if (sender_valid && prevValid && !prevReady) begin
          checkOutput("hold_stable", 64'(actData), 64'(prevData));
        end
        if (sender_valid && sender_ready) begin
          if (expQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL unexpected_flit: got %0h expected none at %0t", actData, $time);
          end else begin
            expData = expQ.pop_front();
            checkOutput("flit_order", 64'(actData), 64'(expData));
          end
        end
        prevValid = sender_valid;
        prevReady = sender_ready;
        prevData  = actData;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] pat;
    rst_n = 1'b0;
    sender_ready = 1'b1;
    sender_vc_ready = 1'b1;
    repeat (2) @(posedge noc_clk);

    // Reset values, then a single 4-flit packet from req0.
    doReset();
    applyStimulus(0, 1, 4);
    expectPacket(0, 1, 4);
    @(posedge noc_clk); #1;
    checkOutput("lat_grant_valid", 64'(sender_valid), 64'd0);
    checkOutput("lat_grant_ready", 64'(req_ready), 64'b0001);
    checkOutput("lat_grant_owner", 64'(owner_idx), 64'd0);
    @(posedge noc_clk); #1;
    checkOutput("lat_hdr_valid", 64'(sender_valid), 64'd1);
    checkOutput("lat_hdr_flag",  64'(sender_is_header), 64'd1);
    for (int k = 1; k < 4; k++) begin
      @(posedge noc_clk); #1;
      checkOutput("stream_valid", 64'(sender_valid), 64'd1);
      checkOutput("stream_flit",  64'(sender_flit), 64'(mkFlit(0, 1, k)));
    end
    checkOutput("stream_tail", 64'(sender_is_tail), 64'd1);
    @(posedge noc_clk); #1;
    checkOutput("after_tail_valid", 64'(sender_valid), 64'd0);
    checkOutput("after_tail_ready", 64'(req_ready), 64'd0);
    waitDrain(20);

    // All four requesters at once from rr_ptr=0: order 0,1,2,3; then 0 and 2.
    doReset();
    for (int r = 0; r < NUM_REQ; r++) applyStimulus(r, 2, 2);
    for (int r = 0; r < NUM_REQ; r++) expectPacket(r, 2, 2);
    waitDrain(100);
    applyStimulus(0, 3, 2);
    applyStimulus(2, 3, 2);
    expectPacket(0, 3, 2);
    expectPacket(2, 3, 2);
    waitDrain(100);

    // req1 owns a packet and stalls mid-packet while req2 waits.
    applyStimulus(1, 4, 4);
    expectPacket(1, 4, 4);
    expectPacket(2, 4, 2);
    waitValid(20);
    checkOutput("hold_owner", 64'(owner_idx), 64'd1);
    srcHold[1] = 1'b1;
    applyStimulus(2, 4, 2);
    repeat (4) begin
      @(posedge noc_clk); #1;
      checkOutput("no_steal_ready", 64'(req_ready[2]), 64'd0);
      checkOutput("no_steal_owner", 64'(owner_idx), 64'd1);
    end
    srcHold[1] = 1'b0;
    waitDrain(100);

    // No VC: header from req3 must wait, then be granted the cycle after.
    sender_vc_ready = 1'b0;
    applyStimulus(3, 5, 2);
    expectPacket(3, 5, 2);
    repeat (5) begin
      @(posedge noc_clk); #1;
      checkOutput("novc_valid", 64'(sender_valid), 64'd0);
      checkOutput("novc_ready", 64'(req_ready), 64'd0);
    end
    sender_vc_ready = 1'b1;
    @(posedge noc_clk); #1;
    checkOutput("vc_grant_ready", 64'(req_ready), 64'b1000);
    checkOutput("vc_grant_owner", 64'(owner_idx), 64'd3);
    sender_vc_ready = 1'b0;
    waitDrain(50);

    // Router backpressure 1,0,0,1 mid-packet; body flits need no VC.
    sender_vc_ready = 1'b1;
    applyStimulus(0, 6, 4);
    expectPacket(0, 6, 4);
    waitValid(20);
    sender_vc_ready = 1'b0;
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      sender_ready = pat[k];
      #1;
      if (!pat[k]) checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
      @(posedge noc_clk); #1;
    end
    sender_ready = 1'b1;
    waitDrain(50);
    sender_vc_ready = 1'b1;
    checkOutput("no_proto_err", 64'(proto_err), 64'd0);

    // Body flit offered with no owner: sticky error, never acknowledged.
    doReset();
    applyRaw(1, 1'b0, 1'b0, 32'hDEAD0001);
    @(posedge noc_clk); #1;
    checkOutput("proto_err_set",  64'(proto_err), 64'd1);
    checkOutput("proto_no_ready", 64'(req_ready), 64'd0);
    repeat (3) @(posedge noc_clk);
    #1;
    srcHold[1] = 1'b1;
    repeat (2) @(posedge noc_clk);
    #1;
    checkOutput("proto_err_sticky", 64'(proto_err), 64'd1);
    checkOutput("proto_no_send",    64'(sender_valid), 64'd0);

    // Reset in the middle of a packet, then recover with a 1-flit packet.
    doReset();
    applyStimulus(2, 7, 6);
    expectPacket(2, 7, 6);
    waitValid(20);
    @(posedge noc_clk); #1;
    doReset();
    applyStimulus(1, 8, 1);
    expectPacket(1, 8, 1);
    waitDrain(20);
    checkOutput("single_owner", 64'(owner_idx), 64'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
